// File: rtl/m_memarb.sv
// Single-port memory arbiter for instruction fetch (I) and data load/store (D).
// D has fixed priority; a starvation counter forces an I grant after MAX_WAIT lost cycles.
module m_memarb #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CW       = 16
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_ireq,
  input  logic [AW-1:0] w_iaddr,
  input  logic          w_dreq,
  input  logic          w_dwe,
  input  logic [AW-1:0] w_daddr,
  input  logic [DW-1:0] w_ddin,
  output logic          w_igrant,
  output logic          w_dgrant,
  output logic          w_istall,
  output logic          w_dstall,
  output logic [AW-1:0] w_maddr,
  output logic          w_mwe,
  output logic [DW-1:0] w_mdin,
  input  logic [DW-1:0] w_mdout,
  output logic [DW-1:0] w_rdata,
  output logic          r_ivld,
  output logic          r_dvld,
  output logic [CW-1:0] r_conf
);

  localparam int unsigned WW    = 4;
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

  logic [WW-1:0] r_wait;
  logic [WW-1:0] wait_nxt;
  logic          both_req;

  assign both_req = w_ireq & w_dreq;

  // I wins only when uncontended or when it has waited long enough
  assign w_igrant = w_ireq & (~w_dreq | (r_wait == MAX_W));
  assign w_dgrant = w_dreq & ~w_igrant;
  assign w_istall = w_ireq & ~w_igrant;
  assign w_dstall = w_dreq & ~w_dgrant;

  assign w_maddr  = w_dgrant ? w_daddr : w_iaddr;
  assign w_mwe    = w_dgrant & w_dwe & w_rst_n;
  assign w_mdin   = w_ddin;
  assign w_rdata  = w_mdout;

  always_comb begin
    wait_nxt = r_wait;
    if (!w_ireq || w_igrant) begin
      wait_nxt = '0;
    end else if (r_wait != MAX_W) begin
      wait_nxt = r_wait + WW'(1);
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wait <= '0;
      r_ivld <= 1'b0;
      r_dvld <= 1'b0;
      r_conf <= '0;
    end else begin
      r_wait <= wait_nxt;
      r_ivld <= w_igrant;
      r_dvld <= w_dgrant & ~w_dwe;
      if (both_req && !(&r_conf)) begin
        r_conf <= r_conf + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_m_memarb.sv
// Directed bench for m_memarb: a behavioural 1-cycle-latency memory plus a CW=4 instance for saturation.
module tb_m_memarb;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          w_clk;
  logic          w_rst_n;
  logic          w_ireq;
  logic [AW-1:0] w_iaddr;
  logic          w_dreq;
  logic          w_dwe;
  logic [AW-1:0] w_daddr;
  logic [DW-1:0] w_ddin;
  logic          w_igrant, w_dgrant, w_istall, w_dstall;
  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mdin, w_mdout, w_rdata;
  logic          r_ivld, r_dvld;
  logic [15:0]   r_conf;

  logic          b_igrant, b_dgrant, b_istall, b_dstall, b_mwe, b_ivld, b_dvld;
  logic [AW-1:0] b_maddr;
  logic [DW-1:0] b_mdin, b_rdata;
  logic [3:0]    b_conf;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_bad   = 0;

  m_memarb #(.AW(AW), .DW(DW), .MAX_WAIT(4), .CW(16)) u_dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_ireq(w_ireq), .w_iaddr(w_iaddr),
    .w_dreq(w_dreq), .w_dwe(w_dwe), .w_daddr(w_daddr), .w_ddin(w_ddin),
    .w_igrant(w_igrant), .w_dgrant(w_dgrant), .w_istall(w_istall), .w_dstall(w_dstall),
    .w_maddr(w_maddr), .w_mwe(w_mwe), .w_mdin(w_mdin), .w_mdout(w_mdout),
    .w_rdata(w_rdata), .r_ivld(r_ivld), .r_dvld(r_dvld), .r_conf(r_conf)
  );

  m_memarb #(.AW(AW), .DW(DW), .MAX_WAIT(4), .CW(4)) u_dut4 (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_ireq(w_ireq), .w_iaddr(w_iaddr),
    .w_dreq(w_dreq), .w_dwe(w_dwe), .w_daddr(w_daddr), .w_ddin(w_ddin),
    .w_igrant(b_igrant), .w_dgrant(b_dgrant), .w_istall(b_istall), .w_dstall(b_dstall),
    .w_maddr(b_maddr), .w_mwe(b_mwe), .w_mdin(b_mdin), .w_mdout(32'h0),
    .w_rdata(b_rdata), .r_ivld(b_ivld), .r_dvld(b_dvld), .r_conf(b_conf)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Single-port synchronous memory, read-before-write
  always @(posedge w_clk) begin
    if (w_mwe) mem[w_maddr] <= w_mdin;
    w_mdout <= mem[w_maddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset;
    w_rst_n = 1'b0;
    tick();
    w_rst_n = 1'b1;
  endtask

  logic [31:0] exp_rd [3];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[5] = 32'h11; mem[6] = 32'h22; mem[7] = 32'h33;
    exp_rd[0] = 32'h11; exp_rd[1] = 32'h22; exp_rd[2] = 32'h33;

    w_rst_n = 1'b0; w_ireq = 1'b0; w_iaddr = '0; w_dreq = 1'b0;
    w_dwe = 1'b0; w_daddr = '0; w_ddin = '0;
    #3;
    chk("rst_ivld", 32'(r_ivld), 32'd0);
    chk("rst_dvld", 32'(r_dvld), 32'd0);
    chk("rst_conf", 32'(r_conf), 32'd0);
    chk("rst_mwe",  32'(w_mwe),  32'd0);
    tick();
    w_rst_n = 1'b1;

    // 1: back-to-back I reads
    w_ireq = 1'b1; w_iaddr = 12'd5;
    #1;
    chk("t1_igrant0", 32'(w_igrant), 32'd1);
    chk("t1_istall0", 32'(w_istall), 32'd0);
    chk("t1_maddr0",  32'(w_maddr),  32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) w_iaddr = AW'(6 + i);
      else       w_ireq = 1'b0;
      #1;
      chk("t1_ivld",  32'(r_ivld), 32'd1);
      chk("t1_rdata", w_rdata, exp_rd[i]);
      if (i < 2) begin
        chk("t1_igrant", 32'(w_igrant), 32'd1);
        chk("t1_istall", 32'(w_istall), 32'd0);
      end
    end

    // 2: one conflict cycle, D wins, then I
    tick();
    w_ireq = 1'b1; w_iaddr = 12'd3; w_dreq = 1'b1; w_dwe = 1'b0; w_daddr = 12'd7;
    #1;
    chk("t2_dgrant", 32'(w_dgrant), 32'd1);
    chk("t2_igrant", 32'(w_igrant), 32'd0);
    chk("t2_istall", 32'(w_istall), 32'd1);
    chk("t2_maddr",  32'(w_maddr),  32'd7);
    tick();
    w_dreq = 1'b0;
    #1;
    chk("t2_igrant1", 32'(w_igrant), 32'd1);
    chk("t2_dvld",    32'(r_dvld),   32'd1);
    chk("t2_drdata",  w_rdata,       32'h33);
    tick();
    w_ireq = 1'b0;
    #1;
    chk("t2_ivld",   32'(r_ivld), 32'd1);
    chk("t2_dvld0",  32'(r_dvld), 32'd0);
    chk("t2_irdata", w_rdata,     32'hA000_0003);
    chk("t2_conf",   32'(r_conf), 32'd1);

    // 3: D held, I forced through on the 5th contended cycle
    do_reset();
    w_ireq = 1'b1; w_iaddr = 12'd4; w_dreq = 1'b1; w_dwe = 1'b0; w_daddr = 12'd2;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_igrant", 32'(w_igrant), (k == 4) ? 32'd1 : 32'd0);
      chk("t3_dgrant", 32'(w_dgrant), (k == 4) ? 32'd0 : 32'd1);
      tick();
    end
    w_ireq = 1'b0; w_dreq = 1'b0;
    #1;
    chk("t3_conf", 32'(r_conf), 32'd6);
    chk("t3_dvld", 32'(r_dvld), 32'd1);

    // 4: store then load of the same word
    tick();
    w_dreq = 1'b1; w_dwe = 1'b1; w_daddr = 12'd9; w_ddin = 32'hDEAD_BEEF;
    #1;
    chk("t4_dgrant", 32'(w_dgrant), 32'd1);
    chk("t4_mwe",    32'(w_mwe),    32'd1);
    chk("t4_maddr",  32'(w_maddr),  32'd9);
    tick();
    w_dwe = 1'b0;
    #1;
    chk("t4_mwe0",  32'(w_mwe),  32'd0);
    chk("t4_sdvld", 32'(r_dvld), 32'd0);
    tick();
    w_dreq = 1'b0;
    #1;
    chk("t4_dvld",  32'(r_dvld), 32'd1);
    chk("t4_rdata", w_rdata,     32'hDEAD_BEEF);

    // 5: async reset while an I read is in flight
    tick();
    w_ireq = 1'b1; w_iaddr = 12'd5;
    tick();
    w_iaddr = 12'd6;
    #1;
    chk("t5_ivld_pre", 32'(r_ivld), 32'd1);
    w_ireq = 1'b0; w_dreq = 1'b1; w_dwe = 1'b1; w_daddr = 12'd20;
    w_rst_n = 1'b0;
    #1;
    chk("t5_ivld_rst", 32'(r_ivld), 32'd0);
    chk("t5_dvld_rst", 32'(r_dvld), 32'd0);
    chk("t5_conf_rst", 32'(r_conf), 32'd0);
    chk("t5_mwe_rst",  32'(w_mwe),  32'd0);
    tick();
    chk("t5_ivld_hold", 32'(r_ivld), 32'd0);
    w_dreq = 1'b0; w_dwe = 1'b0;
    w_rst_n = 1'b1;
    tick();
    w_ireq = 1'b1; w_iaddr = 12'd6;
    #1;
    chk("t5_igrant", 32'(w_igrant), 32'd1);
    chk("t5_ivld0",  32'(r_ivld),   32'd0);
    tick();
    w_ireq = 1'b0;
    #1;
    chk("t5_ivld1", 32'(r_ivld), 32'd1);
    chk("t5_rdata", w_rdata,     32'h22);

    // 6: CW=4 saturation under sustained contention
    do_reset();
    w_ireq = 1'b1; w_iaddr = 12'd1; w_dreq = 1'b1; w_dwe = 1'b0; w_daddr = 12'd2;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("t6_igrant", 32'(b_igrant), ((k % 5) == 4) ? 32'd1 : 32'd0);
      chk("t6_conf",   32'(b_conf),   (k > 15) ? 32'd15 : 32'(k));
      tick();
    end
    w_ireq = 1'b0; w_dreq = 1'b0;
    #1;
    chk("t6_conf_sat", 32'(b_conf), 32'd15);
    chk("t6_conf16",   32'(r_conf), 32'd20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
